disp_scan_ctrl: RTL

//  Time-multiplexes the 4-digit common-anode 7-segment display among up to four data pages
//  (steps, distance, active time, ...). Sequences digit scan from an internal one-cycle enable tick.

---
 rtl/disp_pkg.sv | 32 +++
 rtl/disp_tick_gen.sv | 26 ++
 rtl/disp_scan_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/disp_pkg.sv
// Shared constants, FSM encoding and BCD-to-segment lookup for the display scan controller.
package disp_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int NUM_PAGES  = 4;

    // Segment vectors are {g,f,e,d,c,b,a}, active-low.
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_ON    = 1'b1;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = SEG_DASH;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/disp_tick_gen.sv
// Free-running divider producing a one-cycle tick every P clocks.
module disp_tick_gen #(
    parameter int P = 100000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (P > 1) ? $clog2(P) : 1;

    logic [CW-1:0] cnt_reg;

    assign tick = (cnt_reg == CW'(P - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg <= '0;
        end else if (tick) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Multiplexes up to four BCD pages onto a 4-digit common-anode display with
// inter-digit blanking, frame-aligned page snapshots and round-robin rotation.
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int CLK_HZ      = 100_000_000,
    parameter int SCAN_HZ     = 1000,
    parameter int BLANK_CYC   = 1000,
    parameter int PAGE_FRAMES = 500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] page_data,
    input  logic [15:0] page_dp,
    input  logic [3:0]  page_valid,
    input  logic        hold,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [1:0]  page_idx,
    output logic        frame_start
);

    localparam int P  = CLK_HZ / SCAN_HZ;
    localparam int DW = $clog2(NUM_DIGITS);
    localparam int BW = $clog2(BLANK_CYC + 1);
    localparam int FW = $clog2(PAGE_FRAMES + 2);

    logic          tick;
    logic [0:0]    state_reg;
    logic [BW-1:0] blank_cnt_reg;
    logic [DW-1:0] digit_reg;
    logic [FW-1:0] frame_cnt_reg;
    logic [1:0]    page_idx_reg;
    logic [15:0]   snap_data_reg;
    logic [3:0]    snap_dp_reg;
    logic [3:0]    an_reg;
    logic [6:0]    seg_reg;
    logic          dp_reg;
    logic          frame_start_reg;

    disp_tick_gen #(.P(P)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    logic wrap;
    assign wrap = (state_reg == ST_ON) && tick && (digit_reg == DW'(NUM_DIGITS - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= ST_BLANK;
            blank_cnt_reg <= '0;
            digit_reg     <= '0;
        end else begin
            case (state_reg)
                ST_BLANK: begin
                    if (blank_cnt_reg == BW'(BLANK_CYC - 1)) begin
                        state_reg     <= ST_ON;
                        blank_cnt_reg <= '0;
                    end else begin
                        blank_cnt_reg <= blank_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    if (tick) begin
                        state_reg <= ST_BLANK;
                        digit_reg <= (digit_reg == DW'(NUM_DIGITS - 1)) ? '0 : digit_reg + 1'b1;
                    end
                end
            endcase
        end
    end

    // Search starts one past the current page; offset NUM_PAGES lands back on it,
    // so a lone valid page reselects itself.
    logic [1:0]    nxt_page;
    logic [1:0]    cand_page;
    logic [1:0]    sel_page;
    logic          found;
    logic          rotate;
    logic [FW-1:0] frame_inc;

    always_comb begin
        nxt_page  = page_idx_reg;
        cand_page = page_idx_reg;
        found     = 1'b0;
        for (int k = 1; k <= NUM_PAGES; k++) begin
            cand_page = page_idx_reg + 2'(k);
            if (!found && page_valid[cand_page]) begin
                nxt_page = cand_page;
                found    = 1'b1;
            end
        end
        frame_inc = frame_cnt_reg + 1'b1;
        rotate    = (!hold && (frame_inc >= FW'(PAGE_FRAMES))) || !page_valid[page_idx_reg];
        sel_page  = rotate ? nxt_page : page_idx_reg;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_cnt_reg <= '0;
            page_idx_reg  <= '0;
            snap_data_reg <= '0;
            snap_dp_reg   <= '0;
        end else if (wrap) begin
            if (rotate) begin
                page_idx_reg  <= nxt_page;
                frame_cnt_reg <= '0;
            end else begin
                frame_cnt_reg <= (frame_inc > FW'(PAGE_FRAMES)) ? FW'(PAGE_FRAMES) : frame_inc;
            end
            snap_data_reg <= page_data[{sel_page, 4'b0000} +: 16];
            snap_dp_reg   <= page_dp[{sel_page, 2'b00} +: 4];
        end
    end

    // A digit is blank when it and every digit above it are zero; digit0 never blanks.
    logic [3:0]  cur_nib;
    logic [15:0] upper_digits;
    logic        lz_blank;
    logic        active;

    always_comb begin
        cur_nib      = snap_data_reg[{digit_reg, 2'b00} +: 4];
        upper_digits = snap_data_reg >> {digit_reg, 2'b00};
        lz_blank     = (digit_reg != '0) && (upper_digits == '0);
        active       = (state_reg == ST_ON) && (|page_valid);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            an_reg          <= 4'hF;
            seg_reg         <= SEG_BLANK;
            dp_reg          <= 1'b1;
            frame_start_reg <= 1'b0;
        end else begin
            an_reg          <= active ? ~(4'b0001 << digit_reg) : 4'hF;
            seg_reg         <= (active && !lz_blank) ? bcd_to_seg(cur_nib) : SEG_BLANK;
            dp_reg          <= active ? ~snap_dp_reg[digit_reg] : 1'b1;
            frame_start_reg <= wrap;
        end
    end

    assign an          = an_reg;
    assign seg         = seg_reg;
    assign dp          = dp_reg;
    assign page_idx    = page_idx_reg;
    assign frame_start = frame_start_reg;

endmodule
